// File: rtl/dac_mux_interface.sv
// dac_mux_interface: paces double-buffered multichannel frames out to a shared offset-binary DAC
module dac_mux_interface #(
  parameter int IN_WL = 8,
  parameter int DAC_WL = 12,
  parameter int NCH = 2,
  parameter int SCALE_WL = 2,
  parameter int DIV_WL = 8,
  parameter int CH_WL = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NCH*IN_WL-1:0]   datin,
  input  logic                   datin_vld,
  output logic                   datin_rdy,
  input  logic [SCALE_WL-1:0]    scale,
  input  logic [DIV_WL-1:0]      div,
  input  logic                   clr_underrun,
  output logic [DAC_WL-1:0]      dat2dac,
  output logic [CH_WL-1:0]       dac_ch,
  output logic                   dac_wr,
  output logic                   underrun
);
  localparam logic [DAC_WL-1:0] MID = DAC_WL'(1) << (DAC_WL - 1);
  logic [DIV_WL-1:0] cnt;
  logic [CH_WL-1:0] idx;
  logic [NCH*IN_WL-1:0] hold, active, frame;
  logic hold_full, active_vld, frame_vld;
  logic tick, fstart, accept, hold_full_nxt;
  logic signed [IN_WL-1:0] samp;
  logic signed [DAC_WL-1:0] lj, shifted;
  // tick detection, frame selection (hold feeds the frame-start sample) and sample conversion
  always_comb begin
    tick = cnt >= div;
    fstart = tick && idx == '0;
    accept = datin_vld && datin_rdy;
    hold_full_nxt = accept || (hold_full && !fstart);
    frame = fstart ? hold : active;
    frame_vld = fstart ? hold_full : active_vld;
    samp = frame[idx*IN_WL +: IN_WL];
    lj = DAC_WL'(samp) <<< (DAC_WL - IN_WL);
    shifted = lj >>> scale;
  end
  // tick counter, buffers, channel index, sticky underrun and registered DAC outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      hold_full <= 1'b0;
      active_vld <= 1'b0;
      datin_rdy <= 1'b0;
      dat2dac <= MID;
      dac_ch <= '0;
      dac_wr <= 1'b0;
      underrun <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      hold_full <= hold_full_nxt;
      datin_rdy <= !hold_full_nxt;
      dac_wr <= tick;
      underrun <= (fstart && !hold_full) || (underrun && !clr_underrun);
      if (accept) hold <= datin;
      if (fstart) begin
        active <= hold;
        active_vld <= hold_full;
      end
      if (tick) begin
        dat2dac <= frame_vld ? (shifted ^ MID) : MID;
        dac_ch <= idx;
        idx <= (idx == CH_WL'(NCH - 1)) ? '0 : idx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dac_mux_interface.sv
// tb_dac_mux_interface: table vectors, corner sequences and random traffic against a frame-queue model
module tb_dac_mux_interface;
  localparam int IN_WL = 8, DAC_WL = 12, NCH = 2, SCALE_WL = 2, DIV_WL = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NCH*IN_WL-1:0] datin = '0;
  logic datin_vld = 1'b0, clr_underrun = 1'b0;
  logic datin_rdy, dac_wr, underrun;
  logic [SCALE_WL-1:0] scale = '0;
  logic [DIV_WL-1:0] div = 8'd3;
  logic [DAC_WL-1:0] dat2dac;
  logic [0:0] dac_ch;
  int checks = 0, failures = 0, cyc = 0;

  dac_mux_interface #(.IN_WL(IN_WL), .DAC_WL(DAC_WL), .NCH(NCH), .SCALE_WL(SCALE_WL), .DIV_WL(DIV_WL)) dut (
    .clk(clk), .rst_n(rst_n), .datin(datin), .datin_vld(datin_vld), .datin_rdy(datin_rdy),
    .scale(scale), .div(div), .clr_underrun(clr_underrun), .dat2dac(dat2dac), .dac_ch(dac_ch),
    .dac_wr(dac_wr), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // signed sample scaled to DAC full range, divided by 2^sc (floor), shifted to offset binary
  function automatic int conv(input int s, input int sc);
    int v;
    v = s * (1 << (DAC_WL - IN_WL));
    return (v >>> sc) + (1 << (DAC_WL - 1));
  endfunction

  // reference model: accepted frames wait in a queue, each frame start pops one
  logic [NCH*IN_WL-1:0] hq[$];
  logic [NCH*IN_WL-1:0] act;
  bit act_ok, m_on, e_wr, e_und, e_rdy;
  int m_cnt, m_idx, e_dat, e_ch;
  always @(posedge clk) begin : model
    bit tk, acc, und_set;
    if (!rst_n) begin
      m_on = 1; m_cnt = 0; m_idx = 0; act_ok = 0; hq.delete();
      e_dat = 1 << (DAC_WL - 1); e_ch = 0; e_wr = 0; e_und = 0; e_rdy = 0;
    end else begin
      tk = m_cnt >= int'(div);
      acc = datin_vld && e_rdy;
      und_set = 0;
      e_wr = tk;
      if (tk) begin
        if (m_idx == 0) begin
          act_ok = hq.size() > 0;
          if (act_ok) act = hq.pop_front();
          else und_set = 1;
        end
        e_dat = act_ok ? conv(int'($signed(act[m_idx*IN_WL +: IN_WL])), int'(scale)) : (1 << (DAC_WL - 1));
        e_ch = m_idx;
        m_idx = (m_idx + 1) % NCH;
      end
      if (acc) hq.push_back(datin);
      e_und = und_set || (e_und && !clr_underrun);
      e_rdy = hq.size() == 0;
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  end

  // every cycle: outputs must match the model
  always @(negedge clk) if (m_on) begin
    chk("m_dat2dac", dat2dac, e_dat);
    chk("m_dac_ch", dac_ch, e_ch);
    chk("m_dac_wr", dac_wr, e_wr);
    chk("m_underrun", underrun, e_und);
    chk("m_datin_rdy", datin_rdy, e_rdy);
  end

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 0; datin_vld = 0; clr_underrun = 0;
    repeat (n) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic send(input logic [NCH*IN_WL-1:0] f, input bit keep);
    int t = 0;
    datin = f; datin_vld = 1;
    while (!datin_rdy && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("send_accept", datin_rdy, 1);
    @(negedge clk);
    if (!keep) datin_vld = 0;
  endtask

  task automatic get_strobe(output logic [DAC_WL-1:0] d, output logic [0:0] c, output int at);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!dac_wr && t < 200);
    chk("strobe_seen", dac_wr, 1);
    d = dat2dac; c = dac_ch; at = cyc;
  endtask

  typedef struct { logic [7:0] c0, c1; logic [1:0] sc; logic [11:0] e0, e1; } vec_t;
  vec_t tbl[5];
  logic [15:0] fr[3];

  initial begin : main
    logic [DAC_WL-1:0] d;
    logic [0:0] c;
    int t0, t1;
    tbl[0] = '{8'h80, 8'h7F, 2'd0, 12'h000, 12'hFF0};
    tbl[1] = '{8'h40, 8'hC0, 2'd2, 12'h900, 12'h700};
    tbl[2] = '{8'h80, 8'h00, 2'd3, 12'h700, 12'h800};
    tbl[3] = '{8'h01, 8'hFF, 2'd1, 12'h808, 12'h7F8};
    tbl[4] = '{8'h7F, 8'h80, 2'd3, 12'h8FE, 12'h700};
    // reset values held, ready one cycle after release
    repeat (5) @(negedge clk);
    chk("rst_dat", dat2dac, 12'h800);
    chk("rst_wr", dac_wr, 0);
    chk("rst_rdy", datin_rdy, 0);
    chk("rst_und", underrun, 0);
    rst_n = 1;
    @(negedge clk);
    chk("rdy_after_release", datin_rdy, 1);
    // table vectors, each on a freshly reset block with the frame offered before the first tick
    foreach (tbl[i]) begin
      do_reset(3);
      scale = tbl[i].sc;
      send({tbl[i].c1, tbl[i].c0}, 0);
      get_strobe(d, c, t0);
      chk("tbl_ch0", c, 0);
      chk("tbl_d0", d, tbl[i].e0);
      get_strobe(d, c, t1);
      chk("tbl_ch1", c, 1);
      chk("tbl_d1", d, tbl[i].e1);
      chk("wr_period", t1 - t0, 4);
    end
    // underrun: midscale output, sticky, set beats clear, clear alone clears
    do_reset(3);
    scale = 0;
    get_strobe(d, c, t0);
    chk("und_dat0", d, 12'h800);
    chk("und_set", underrun, 1);
    get_strobe(d, c, t0);
    chk("und_dat1", d, 12'h800);
    chk("und_sticky", underrun, 1);
    repeat (3) @(negedge clk);
    clr_underrun = 1;
    @(negedge clk);
    clr_underrun = 0;
    chk("und_set_wins", underrun, 1);
    @(negedge clk);
    clr_underrun = 1;
    @(negedge clk);
    clr_underrun = 0;
    chk("und_cleared", underrun, 0);
    // three back-to-back frames with valid held high
    do_reset(3);
    fr[0] = 16'h2010; fr[1] = 16'hF030; fr[2] = 16'h7F80;
    fork
      begin
        for (int k = 0; k < 3; k++) send(fr[k], 1);
        datin_vld = 0;
      end
      begin
        logic [DAC_WL-1:0] dd;
        logic [0:0] cc;
        int tt;
        logic [15:0] f;
        for (int j = 0; j < 6; j++) begin
          get_strobe(dd, cc, tt);
          f = fr[j / 2];
          chk("b2b_ch", cc, j % 2);
          chk("b2b_dat", dd, conv(int'($signed(f[(j % 2)*8 +: 8])), 0));
        end
      end
    join
    // reset between ch0 and ch1 strobes: frame aborted, new frame restarts at ch0
    do_reset(3);
    send(16'h2010, 0);
    get_strobe(d, c, t0);
    chk("abort_first_ch", c, 0);
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("abort_dat", dat2dac, 12'h800);
    chk("abort_wr", dac_wr, 0);
    chk("abort_ch", dac_ch, 0);
    chk("abort_rdy", datin_rdy, 0);
    @(negedge clk);
    rst_n = 1;
    send(16'h5540, 0);
    get_strobe(d, c, t0);
    chk("restart_ch", c, 0);
    chk("restart_dat", d, 12'hC00);
    // random traffic, divider and scale changes, clears and occasional resets
    do_reset(3);
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      rst_n = ($urandom_range(0, 399) != 0);
      datin = 16'($urandom);
      datin_vld = ($urandom_range(0, 2) != 0);
      scale = 2'($urandom);
      clr_underrun = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 49) == 0) div = 8'($urandom_range(0, 5));
    end
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
